// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - Kyber NTT constants, coefficient/mode types and sign-extension helper.
package ntt_pkg;

    localparam int Q             = 3329;
    localparam int QINV          = -3327;
    localparam int BARRETT_V     = 20159;
    localparam int BARRETT_SHIFT = 26;
    localparam int BARRETT_RND   = 1 << (BARRETT_SHIFT - 1);
    localparam int MONT_ONE      = 2285;

    typedef logic signed [15:0] coeff_t;

    typedef enum logic {
        BF_CT = 1'b0,
        BF_GS = 1'b1
    } bf_mode_e;

    function automatic logic signed [31:0] sext32(coeff_t x);
        return {{16{x[15]}}, x};
    endfunction

endpackage

// File: rtl/ntt_butterfly_if.sv
// rtl/ntt_butterfly_if.sv - Coefficient-pair input stream and result output stream of the butterfly.
interface ntt_butterfly_if
    import ntt_pkg::*;
#(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    coeff_t           in_a;
    coeff_t           in_b;
    coeff_t           in_zeta;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    coeff_t           out_a;
    coeff_t           out_b;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_zeta, in_tag, out_ready,
        output in_ready, out_valid, out_a, out_b, out_tag
    );

    modport master (
        output in_valid, in_mode, in_a, in_b, in_zeta, in_tag, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_tag
    );
endinterface

// File: rtl/ntt_barrett.sv
// rtl/ntt_barrett.sv - Combinational Barrett reduction of an int16 coefficient modulo Q.
module ntt_barrett
    import ntt_pkg::*;
(
    input  coeff_t x,
    output coeff_t r
);
    logic signed [31:0] xe;
    logic signed [31:0] q_est;

    always_comb begin
        xe    = sext32(x);
        q_est = (xe * BARRETT_V + BARRETT_RND) >>> BARRETT_SHIFT;
        r     = coeff_t'(xe - q_est * Q);
    end
endmodule

// File: rtl/ntt_mul.sv
// rtl/ntt_mul.sv - Combinational Montgomery multiply: (x*y*2^-16) mod Q, result in (-Q,Q).
module ntt_mul
    import ntt_pkg::*;
(
    input  coeff_t x,
    input  coeff_t y,
    output coeff_t r
);
    logic signed [31:0] prod;
    logic signed [31:0] diff;
    coeff_t             m;

    // m*Q cancels the low half of the product, so the upper half is exact.
    always_comb begin
        prod = sext32(x) * sext32(y);
        m    = coeff_t'(prod * QINV);
        diff = prod - sext32(m) * Q;
        r    = coeff_t'(diff >>> 16);
    end
endmodule

// File: rtl/ntt_butterfly.sv
// rtl/ntt_butterfly.sv - Three-stage CT/GS NTT butterfly with a single global stall enable.
module ntt_butterfly
    import ntt_pkg::*;
#(
    parameter int TAG_W = 4
)
(
    input  logic            clk,
    input  logic            rst,
    ntt_butterfly_if.slave  bus
);
    typedef struct packed {
        bf_mode_e         mode;
        coeff_t           a;
        coeff_t           b;
        coeff_t           zeta;
        logic [TAG_W-1:0] tag;
    } s1_t;

    // After the multiply, a holds a (CT) or a+b (GS) and b holds the product t.
    typedef struct packed {
        bf_mode_e         mode;
        coeff_t           a;
        coeff_t           b;
        logic [TAG_W-1:0] tag;
    } s2_t;

    s1_t              s1, s1_next;
    s2_t              s2, s2_next;
    logic             v1, v2, v3;
    logic             en;
    coeff_t           mul_in, mul_out, red_out;
    coeff_t           oa, ob, oa_next, ob_next;
    logic [TAG_W-1:0] otag;

    assign en            = ~v3 | bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = v3;
    assign bus.out_a     = oa;
    assign bus.out_b     = ob;
    assign bus.out_tag   = otag;

    ntt_mul u_mul (
        .x (s1.zeta),
        .y (mul_in),
        .r (mul_out)
    );

    ntt_barrett u_barrett (
        .x (s2.a),
        .r (red_out)
    );

    always_comb begin
        s1_next = '{mode: bf_mode_e'(bus.in_mode), a: bus.in_a, b: bus.in_b,
                    zeta: bus.in_zeta, tag: bus.in_tag};
        mul_in  = (s1.mode == BF_GS) ? coeff_t'(s1.b - s1.a) : s1.b;
        s2_next = '{mode: s1.mode, a: (s1.mode == BF_GS) ? coeff_t'(s1.a + s1.b) : s1.a,
                    b: mul_out, tag: s1.tag};
        oa_next = (s2.mode == BF_GS) ? red_out : coeff_t'(s2.a + s2.b);
        ob_next = (s2.mode == BF_GS) ? s2.b    : coeff_t'(s2.a - s2.b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            s1   <= '0;
            s2   <= '0;
            oa   <= '0;
            ob   <= '0;
            otag <= '0;
        end else if (en) begin
            v1   <= bus.in_valid;
            s1   <= s1_next;
            v2   <= v1;
            s2   <= s2_next;
            v3   <= v2;
            oa   <= oa_next;
            ob   <= ob_next;
            otag <= s2.tag;
        end
    end
endmodule

// File: tb/tb_ntt_butterfly.sv
// tb/tb_ntt_butterfly.sv - Directed vector table plus stall, reset and random scoreboard sequences.
module tb_ntt_butterfly;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntt_butterfly_if #(.TAG_W(TW)) bus ();
    ntt_butterfly #(.TAG_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { bit mode; int a; int b; int zeta; int ea; int eb; } vec_t;
    typedef struct { int a; int b; logic [TW-1:0] tag; } exp_t;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   first_out_cyc = 0;
    int   last_out_cyc = 0;
    exp_t expq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic signed [31:0] act, logic signed [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic shortint fqmul_m(shortint z, shortint b);
        int p, r;
        shortint m;
        p = int'(z) * int'(b);
        m = shortint'(p * -3327);
        r = p - int'(m) * 3329;
        return shortint'(r >>> 16);
    endfunction

    function automatic shortint barrett_m(shortint x);
        int t;
        t = ((20159 * int'(x) + (1 << 25)) >>> 26) * 3329;
        return shortint'(int'(x) - t);
    endfunction

    function automatic exp_t model(bit mode, int a, int b, int zeta, int tag);
        exp_t    e;
        shortint sa, sb, sz, t;
        sa = shortint'(a);
        sb = shortint'(b);
        sz = shortint'(zeta);
        if (!mode) begin
            t   = fqmul_m(sz, sb);
            e.a = int'(shortint'(sa + t));
            e.b = int'(shortint'(sa - t));
        end else begin
            e.a = int'(barrett_m(shortint'(sa + sb)));
            e.b = int'(fqmul_m(sz, shortint'(sb - sa)));
        end
        e.tag = TW'(tag);
        return e;
    endfunction

    function automatic int rnd_coeff();
        return int'($urandom_range(0, 6656)) - 3328;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit mode, int a, int b, int zeta, int tag);
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_a     = 16'(a);
        bus.in_b     = 16'(b);
        bus.in_zeta  = 16'(zeta);
        bus.in_tag   = TW'(tag);
        #1;
    endtask

    task automatic drain(string name);
        for (int w = 0; w < 12 && expq.size() > 0; w++) tick();
        check(name, expq.size(), 0);
        expq.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (expq.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = expq.pop_front();
                check("out_a", bus.out_a, e.a);
                check("out_b", bus.out_b, e.b);
                check("out_tag", bus.out_tag, e.tag);
            end
            if (n_out == 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            n_out++;
        end
    end

    initial begin
        vec_t vt[7];
        exp_t pend[6];
        int   pa[6], pb[6], pz[6];
        int   lat, k, n_before, tag;
        bit   acc, cm;
        int   ca, cb, ct, cz, cx;
        logic [TW-1:0] ctag;

        vt[0] = '{1'b0,   100,   200,    0,    100,   100};
        vt[1] = '{1'b0,    10,     1, 2285,     11,     9};
        vt[2] = '{1'b1,     5,     7, 2285,     12,     2};
        vt[3] = '{1'b1,  3000,  3000, 1234,   -658,     0};
        vt[4] = '{1'b0,     0,    -5, 2285,     -5,     5};
        vt[5] = '{1'b1,  3000, -3000, 2285,      0,   658};
        vt[6] = '{1'b0, 32767,     1, 2285, -32768, 32766};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.in_zeta = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_a", bus.out_a, 0);
        check("rst_out_b", bus.out_b, 0);
        check("rst_out_tag", bus.out_tag, 0);
        check("rst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;

        // Directed table: one pair at a time, latency counted from the presenting cycle.
        for (int i = 0; i < 7; i++) begin
            drive(vt[i].mode, vt[i].a, vt[i].b, vt[i].zeta, i);
            expq.push_back('{vt[i].ea, vt[i].eb, TW'(i)});
            check("vec_in_ready", bus.in_ready, 1);
            tick();
            bus.in_valid = 1'b0;
            lat = 1;
            while (bus.out_valid !== 1'b1 && lat < 10) begin
                tick();
                lat++;
            end
            check("vec_latency", lat, 3);
            tick();
        end
        drain("vec_drain");

        // Back-to-back, alternating modes, tags 0..15.
        n_out = 0;
        for (int i = 0; i < 16; i++) begin
            ca = rnd_coeff(); cb = rnd_coeff(); cz = rnd_coeff();
            drive(i[0], ca, cb, cz, i);
            expq.push_back(model(i[0], ca, cb, cz, i));
            check("b2b_in_ready", bus.in_ready, 1);
            tick();
        end
        bus.in_valid = 1'b0;
        drain("b2b_drain");
        check("b2b_count", n_out, 16);
        check("b2b_span", last_out_cyc - first_out_cyc, 15);

        // Stall with a full pipe: only three pairs fit, outputs frozen while out_ready=0.
        for (int i = 0; i < 6; i++) begin
            pa[i] = rnd_coeff(); pb[i] = rnd_coeff(); pz[i] = rnd_coeff();
            pend[i] = model(i[1], pa[i], pb[i], pz[i], 8 + i);
        end
        bus.out_ready = 1'b0;
        n_before = n_out;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            drive(k[1], pa[k], pb[k], pz[k], 8 + k);
            acc = bus.in_ready;
            tick();
            if (acc) begin
                expq.push_back(pend[k]);
                k++;
            end
        end
        check("stall_accepted", k, 3);
        ca = bus.out_a; cb = bus.out_b; ctag = bus.out_tag;
        check("stall_head_a", ca, pend[0].a);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_hold_a", bus.out_a, ca);
            check("stall_hold_b", bus.out_b, cb);
            check("stall_hold_tag", bus.out_tag, ctag);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain("stall_drain");
        check("stall_out_count", n_out - n_before, 3);

        // Reset with three pairs in flight: none of them may ever appear.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 100 + i, 7, 2285, i);
            tick();
        end
        bus.in_valid = 1'b0;
        check("prerst_out_valid", bus.out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_a", bus.out_a, 0);
        check("midrst_out_tag", bus.out_tag, 0);
        bus.out_ready = 1'b1;
        n_before = n_out;
        for (int c = 0; c < 6; c++) tick();
        check("midrst_no_emit", n_out - n_before, 0);

        // Random traffic with random backpressure against the reference model.
        tag = 0;
        n_before = n_out;
        for (int c = 0; c < 150; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
                cm = bit'($urandom_range(0, 1));
                cx = rnd_coeff(); ct = rnd_coeff(); cz = rnd_coeff();
                drive(cm, cx, ct, cz, tag);
            end else begin
                #1;
            end
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) begin
                expq.push_back(model(cm, cx, ct, cz, tag));
                tag++;
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain("rand_drain");
        check("rand_out_count", n_out - n_before, tag);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
